// File: rtl/msrh_snoop_req_queue_pkg.sv
// Shared widths and types for the snoop request queue slice: physical address,
// D-cache line geometry, queue entry and queue FSM encodings.
package riscv_pkg;
   localparam int PADDR_W = 56;
endpackage

package msrh_conf_pkg;
   localparam int DCACHE_DATA_W = 128;
endpackage

package msrh_lsu_pkg;
   localparam int DCACHE_DATA_B_W = msrh_conf_pkg::DCACHE_DATA_W / 8;
   localparam int SNOOP_TAG_W     = 4;

   typedef struct packed {
      logic [riscv_pkg::PADDR_W-1:0] paddr;
      logic [SNOOP_TAG_W-1:0]        tag;
   } snoop_req_entry_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RESP = 2'd1,
      RESP      = 2'd2
   } snoop_q_state_t;

   typedef struct packed {
      logic [riscv_pkg::PADDR_W-1:0] paddr;
   } snoop_req_t;

   typedef struct packed {
      logic [msrh_conf_pkg::DCACHE_DATA_W-1:0] data;
      logic [DCACHE_DATA_B_W-1:0]              be;
   } snoop_resp_t;
endpackage

// File: rtl/snoop_if.sv
// Snoop channel into the core's snoop top: one-cycle request pulse, merged
// L1D/STQ response returned later as a one-cycle valid.
interface snoop_if;
   import msrh_lsu_pkg::*;

   logic        req_valid;
   snoop_req_t  req_payload;
   logic        resp_valid;
   snoop_resp_t resp_payload;

   modport master (output req_valid, req_payload, input resp_valid, resp_payload);
   modport slave  (input req_valid, req_payload, output resp_valid, resp_payload);
endinterface

// File: rtl/msrh_snoop_req_queue_fifo.sv
// Power-of-two circular FIFO for pending snoop requests; pointers wrap naturally.
module msrh_snoop_req_fifo
   import msrh_lsu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = snoop_req_entry_t
)
(
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_push,
   input  entry_t                   i_push_entry,
   input  logic                     i_pop,
   output entry_t                   o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int PTR_W = $clog2(DEPTH);

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage is not reset; only the pointers and count define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_entry;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
endmodule

// File: rtl/msrh_snoop_req_queue.sv
// Queues external snoop requests and issues them one at a time to the snoop top.
// Optional watchdog: define MSRH_SNOOP_TIMEOUT_EN.
module msrh_snoop_req_queue
   import msrh_lsu_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TAG_W          = 4,
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic                                    i_clk,
   input  logic                                    i_reset_n,
   input  logic                                    i_ext_req_valid,
   output logic                                    o_ext_req_ready,
   input  logic [riscv_pkg::PADDR_W-1:0]           i_ext_req_paddr,
   input  logic [TAG_W-1:0]                        i_ext_req_tag,
   output logic                                    o_ext_resp_valid,
   input  logic                                    i_ext_resp_ready,
   output logic [TAG_W-1:0]                        o_ext_resp_tag,
   output logic [msrh_conf_pkg::DCACHE_DATA_W-1:0] o_ext_resp_data,
   output logic [DCACHE_DATA_B_W-1:0]              o_ext_resp_be,
   output logic                                    o_ext_resp_err,
   snoop_if.master                                 snoop_if
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   if ((TAG_W != SNOOP_TAG_W) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
       (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
      $error("msrh_snoop_req_queue: unsupported parameter set");
   end

   snoop_q_state_t                          r_state;
   logic                                    r_req_valid;
   logic [riscv_pkg::PADDR_W-1:0]           r_req_paddr;
   logic                                    r_resp_valid;
   logic [TAG_W-1:0]                        r_tag;
   logic [msrh_conf_pkg::DCACHE_DATA_W-1:0] r_data;
   logic [DCACHE_DATA_B_W-1:0]              r_be;
   logic                                    r_err;
   logic                                    r_drain;
   logic                                    w_timeout;
   logic                                    w_push;
   logic                                    w_pop;
   logic                                    w_full;
   logic                                    w_empty;
   logic [CNT_W-1:0]                        w_count;
   snoop_req_entry_t                        w_head;

   assign o_ext_req_ready = (w_count != CNT_W'(DEPTH));
   assign w_push          = i_ext_req_valid & ~w_full;
   assign w_pop           = (r_state == IDLE) & ~w_empty & ~r_drain;

   msrh_snoop_req_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (snoop_req_entry_t)
   ) u_fifo (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_push       (w_push),
      .i_push_entry ('{paddr: i_ext_req_paddr, tag: i_ext_req_tag}),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_count      (w_count)
   );

`ifdef MSRH_SNOOP_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
   logic [WDOG_W-1:0] r_wdog;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n)                r_wdog <= '0;
      else if (r_state == WAIT_RESP) r_wdog <= r_wdog + WDOG_W'(1);
      else                           r_wdog <= '0;
   end

   assign w_timeout = (r_state == WAIT_RESP) && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= IDLE;
         r_req_valid  <= 1'b0;
         r_req_paddr  <= '0;
         r_resp_valid <= 1'b0;
         r_tag        <= '0;
         r_data       <= '0;
         r_be         <= '0;
         r_err        <= 1'b0;
         r_drain      <= 1'b0;
      end else begin
         // The snoop top has no ready, so the request is a single-cycle pulse.
         r_req_valid <= w_pop;
         if (snoop_if.resp_valid && (r_state != WAIT_RESP) && r_drain) r_drain <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_req_paddr <= w_head.paddr;
                  r_tag       <= w_head.tag;
                  r_state     <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               // A real response in the timeout cycle takes priority.
               if (snoop_if.resp_valid) begin
                  r_data       <= snoop_if.resp_payload.data;
                  r_be         <= snoop_if.resp_payload.be;
                  r_err        <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else if (w_timeout) begin
                  r_data       <= '0;
                  r_be         <= '0;
                  r_err        <= 1'b1;
                  r_resp_valid <= 1'b1;
                  r_drain      <= 1'b1;
                  r_state      <= RESP;
               end
            end
            RESP: begin
               if (i_ext_resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SIMULATION
   always_ff @(posedge i_clk) begin
      if (i_reset_n && snoop_if.resp_valid && (r_state != WAIT_RESP) && !r_drain)
         $fatal(1, "msrh_snoop_req_queue: snoop response with no snoop outstanding");
   end
`endif

   assign snoop_if.req_valid         = r_req_valid;
   assign snoop_if.req_payload.paddr = r_req_paddr;
   assign o_ext_resp_valid           = r_resp_valid;
   assign o_ext_resp_tag             = r_tag;
   assign o_ext_resp_data            = r_data;
   assign o_ext_resp_be              = r_be;
   assign o_ext_resp_err             = r_err;
endmodule
